// File: rtl/seq_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_RETIRE = 3'd4
    } seq_state_t;

    localparam int SEQ_CNT_W = 32;

endpackage

// File: rtl/core_sequencer_bp_match.sv
// PC breakpoint comparator bank; raises hit when any enabled slot equals pc.
module bp_match #(
    parameter int NUM_BP = 2
) (
    input  logic [31:0]          pc,
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [32*NUM_BP-1:0] bp_addr,
    output logic                 hit
);

    // OR-reduce the per-slot address matches
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            hit = hit | (bp_en[i] & (bp_addr[32*i +: 32] == pc));
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle phase sequencer with run/halt/step debug control, PC breakpoints
// and a retired-instruction counter; all outputs are registered.
module core_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_BP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 halt_req,
    input  logic [NUM_BP-1:0]    bp_en,
    input  logic [32*NUM_BP-1:0] bp_addr,
    input  logic [31:0]          pc,
    input  logic                 mem_access,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 reg_wr_en,
    output logic                 mem_wr_en,
    output logic                 halted,
    output logic                 bp_hit,
    output logic [31:0]          retire_count,
    output logic [2:0]           state
);

    seq_state_t           state_r;
    seq_state_t           state_nxt_s;
    logic                 step_pend_r;
    logic                 halt_pend_r;
    logic                 skip_bp_r;
    logic                 bp_hit_r;
    logic                 halted_r;
    logic                 pc_en_r;
    logic                 reg_wr_en_r;
    logic                 mem_wr_en_r;
    logic [SEQ_CNT_W-1:0] retire_count_r;
    logic                 bp_match_s;

    bp_match #(
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .pc      (pc),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .hit     (bp_match_s)
    );

    // Next-state decision for the phase FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_HALT: begin
                if (step_req || run_req) state_nxt_s = S_FETCH;
                else                     state_nxt_s = S_HALT;
            end
            S_FETCH: begin
                if (bp_match_s && !skip_bp_r) state_nxt_s = S_HALT;
                else                          state_nxt_s = S_EXEC;
            end
            S_EXEC: begin
                if (mem_access) state_nxt_s = S_MEM;
                else            state_nxt_s = S_RETIRE;
            end
            S_MEM: begin
                if (mem_ready) state_nxt_s = S_RETIRE;
                else           state_nxt_s = S_MEM;
            end
            S_RETIRE: begin
                if (step_pend_r || halt_pend_r || !run_req) state_nxt_s = S_HALT;
                else                                        state_nxt_s = S_FETCH;
            end
            default: state_nxt_s = S_HALT;
        endcase
    end

    // State, debug flags, counter and outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_HALT;
            step_pend_r    <= 1'b0;
            halt_pend_r    <= 1'b0;
            skip_bp_r      <= 1'b0;
            bp_hit_r       <= 1'b0;
            halted_r       <= 1'b1;
            pc_en_r        <= 1'b0;
            reg_wr_en_r    <= 1'b0;
            mem_wr_en_r    <= 1'b0;
            retire_count_r <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            halted_r    <= (state_nxt_s == S_HALT);
            pc_en_r     <= (state_nxt_s == S_RETIRE);
            reg_wr_en_r <= (state_nxt_s == S_RETIRE);
            mem_wr_en_r <= (state_nxt_s == S_MEM);
            case (state_r)
                S_HALT: begin
                    // skip_bp lets the instruction sitting on a breakpoint resume
                    if (step_req) begin
                        step_pend_r <= 1'b1;
                        skip_bp_r   <= 1'b1;
                    end else if (run_req) begin
                        skip_bp_r   <= 1'b1;
                    end
                    if (state_nxt_s != S_HALT) bp_hit_r <= 1'b0;
                end
                S_FETCH: begin
                    skip_bp_r <= 1'b0;
                    if (state_nxt_s == S_HALT) bp_hit_r <= 1'b1;
                    if (halt_req) halt_pend_r <= 1'b1;
                end
                S_EXEC, S_MEM: begin
                    if (halt_req) halt_pend_r <= 1'b1;
                end
                S_RETIRE: begin
                    retire_count_r <= retire_count_r + 32'd1;
                    if (state_nxt_s == S_HALT) begin
                        step_pend_r <= 1'b0;
                        halt_pend_r <= 1'b0;
                    end else if (halt_req) begin
                        halt_pend_r <= 1'b1;
                    end
                end
                default: begin
                    step_pend_r <= 1'b0;
                    halt_pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc_en        = pc_en_r;
    assign reg_wr_en    = reg_wr_en_r;
    assign mem_wr_en    = mem_wr_en_r;
    assign halted       = halted_r;
    assign bp_hit       = bp_hit_r;
    assign retire_count = retire_count_r;
    assign state        = state_r;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized self-checking bench for core_sequencer against an instruction-level
// timeline model (per-instruction latencies, breakpoint and halt truncation).
module tb_core_sequencer;

    localparam int NB = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            run_req;
    logic            step_req;
    logic            halt_req;
    logic [NB-1:0]   bp_en;
    logic [32*NB-1:0] bp_addr;
    logic [31:0]     pc;
    logic            mem_access;
    logic            mem_ready;
    logic            pc_en;
    logic            reg_wr_en;
    logic            mem_wr_en;
    logic            halted;
    logic            bp_hit;
    logic [31:0]     retire_count;
    logic [2:0]      state;

    int          checks_total = 0;
    int          checks_passed = 0;
    logic [31:0] cnt_m = 32'd0;
    logic [31:0] pc_m = 32'd0;
    bit          bp_hit_m = 1'b0;

    core_sequencer #(.NUM_BP(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .run_req      (run_req),
        .step_req     (step_req),
        .halt_req     (halt_req),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .pc           (pc),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .reg_wr_en    (reg_wr_en),
        .mem_wr_en    (mem_wr_en),
        .halted       (halted),
        .bp_hit       (bp_hit),
        .retire_count (retire_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit bp_m(input logic [31:0] a);
        bit h = 1'b0;
        for (int s = 0; s < NB; s++) begin
            if (bp_en[s] && (bp_addr[32*s +: 32] == a)) h = 1'b1;
        end
        return h;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_state"},  {29'd0, state}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd1);
        check({tag, "_pc_en"},  {31'd0, pc_en}, 32'd0);
        check({tag, "_rwen"},   {31'd0, reg_wr_en}, 32'd0);
        check({tag, "_mwen"},   {31'd0, mem_wr_en}, 32'd0);
        check({tag, "_count"},  retire_count, cnt_m);
        check({tag, "_bp_hit"}, {31'd0, bp_hit}, {31'd0, bp_hit_m});
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            run_req    = 1'b0;
            step_req   = 1'b0;
            halt_req   = 1'($urandom_range(0, 1));
            mem_access = 1'($urandom_range(0, 1));
            mem_ready  = 1'($urandom_range(0, 1));
            pc         = $urandom;
            @(posedge clk); #1;
            check_idle("idle");
        end
        @(negedge clk);
        halt_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        @(posedge clk); #1;
        cnt_m = 32'd0;
        bp_hit_m = 1'b0;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode: 0 free-run n instructions, 1 step with run_req=0, 2 step with run_req=1
    task automatic run_seg(input int n, input int mode, input int halt_k, input int fix_n);
        int nn[17];
        int st[18];
        int last, stop_bp, t_end, hp, cur, retired;
        bit pcen, memwr;
        logic [31:0] cnt_exp;
        for (int i = 0; i < n; i++) begin
            if (fix_n >= 0) nn[i] = fix_n;
            else if ($urandom_range(0, 1) == 1) nn[i] = int'($urandom_range(1, 4));
            else nn[i] = 0;
        end
        st[0] = 0;
        for (int i = 0; i < n; i++) st[i+1] = st[i] + 3 + nn[i];
        last = (mode != 0) ? 0 : n - 1;
        if (halt_k >= 0 && halt_k < last) last = halt_k;
        stop_bp = -1;
        for (int i = 1; i <= last; i++) begin
            if (stop_bp < 0 && bp_m(pc_m + 32'(4 * i))) stop_bp = i;
        end
        if (stop_bp >= 0) last = stop_bp - 1;
        t_end = (stop_bp >= 0) ? st[stop_bp] + 1 : st[last+1];
        hp = -1;
        if (halt_k >= 0 && halt_k <= last) hp = st[halt_k] + int'($urandom_range(1, 2 + nn[halt_k]));
        for (int e = 0; e <= t_end; e++) begin
            @(negedge clk);
            cur = 0;
            for (int i = 0; i < n; i++) if (e > st[i] && e <= st[i+1]) cur = i;
            pc         = pc_m + 32'(4 * cur);
            mem_access = (nn[cur] > 0);
            if (nn[cur] > 0 && e == st[cur] + 2 + nn[cur]) mem_ready = 1'b1;
            else if (e <= st[cur] + 1)                     mem_ready = 1'($urandom_range(0, 1));
            else                                           mem_ready = 1'b0;
            run_req  = (mode == 0) ? (e == 0 || cur < n - 1) : (mode == 2);
            step_req = (mode != 0 && e == 0);
            halt_req = (e == hp);
            @(posedge clk); #1;
            pcen = 1'b0; memwr = 1'b0; retired = 0;
            for (int i = 0; i <= last; i++) begin
                pcen  |= (e == st[i] + 2 + nn[i]);
                memwr |= (e >= st[i] + 2 && e <= st[i] + 1 + nn[i]);
                if (st[i+1] <= e) retired++;
            end
            cnt_exp = cnt_m + 32'(retired);
            check("pc_en",        {31'd0, pc_en}, {31'd0, pcen});
            check("reg_wr_en",    {31'd0, reg_wr_en}, {31'd0, pcen});
            check("mem_wr_en",    {31'd0, mem_wr_en}, {31'd0, memwr});
            check("halted",       {31'd0, halted}, (e == t_end) ? 32'd1 : 32'd0);
            check("bp_hit",       {31'd0, bp_hit}, (e == t_end && stop_bp >= 0) ? 32'd1 : 32'd0);
            check("retire_count", retire_count, cnt_exp);
        end
        @(negedge clk);
        step_req = 1'b0; halt_req = 1'b0; run_req = 1'b0;
        cnt_m    = cnt_m + 32'(last + 1);
        pc_m     = pc_m + 32'(4 * (last + 1));
        bp_hit_m = (stop_bp >= 0);
    endtask

    initial begin
        rst = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        bp_en = '0; bp_addr = '0; pc = 32'd0; mem_access = 1'b0; mem_ready = 1'b0;
        do_reset();
        idle(2);

        // plain run, memory wait of 3 cycles, steps, halt mid-instruction
        run_seg(4, 0, -1, 0);
        idle(1);
        run_seg(1, 0, -1, 3);
        run_seg(3, 0, -1, -1);
        run_seg(1, 1, -1, -1);
        run_seg(1, 2, -1, -1);
        run_seg(4, 0, 1, 0);
        idle(1);

        // breakpoint at 0x10 in slot 1, then step over it and resume
        do_reset();
        pc_m    = 32'd0;
        bp_en   = 2'b10;
        bp_addr = {32'h0000_0010, 32'h0000_0008};
        run_seg(8, 0, -1, 0);
        check("bp_stop_count", retire_count, 32'd4);
        run_seg(1, 1, -1, -1);
        run_seg(3, 0, -1, -1);
        idle(2);

        for (int r = 0; r < 30; r++) begin
            int n;
            int mode;
            int hk;
            n    = int'($urandom_range(1, 8));
            mode = int'($urandom_range(0, 2));
            hk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            bp_en = NB'($urandom_range(0, 3));
            for (int s = 0; s < NB; s++) bp_addr[32*s +: 32] = pc_m + 32'(4 * $urandom_range(0, 8));
            run_seg(n, mode, hk, -1);
            idle(int'($urandom_range(1, 3)));
        end

        // reset while in the memory phase
        bp_en = '0;
        @(negedge clk);
        run_req = 1'b1; mem_access = 1'b1; mem_ready = 1'b0; pc = pc_m;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_state", {29'd0, state}, 32'd3);
        check("pre_rst_mwen",  {31'd0, mem_wr_en}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        cnt_m = 32'd0;
        bp_hit_m = 1'b0;
        check_idle("rst_in_mem");
        @(negedge clk);
        rst = 1'b0; run_req = 1'b0;
        idle(3);

        // counter wrap
        force dut.retire_count_r = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_count_r;
        cnt_m = 32'hFFFF_FFFF;
        idle(1);
        run_seg(1, 1, -1, 0);
        check("wrap_zero", retire_count, 32'd0);
        idle(1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle sequencer for the RV32I core. It breaks each instruction into FETCH, EXEC, optional MEM, and RETIRE phases, and gates the PC update, register-file write and data-memory write to the correct phase. It also provides run/halt/single-step debug control, PC breakpoints and a retired-instruction counter. It sits beside `control` in `top`: its enables are ANDed with `RegWr` and `MemWr`, and with the PC register load.

## Interface
Parameters:
- `NUM_BP`, default 2: number of PC breakpoint comparators.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `run_req`  in  1: level; 1 = free-run, 0 = stop at the next instruction boundary.
- `step_req`  in  1: pulse; execute exactly one instruction when halted.
- `halt_req`  in  1: pulse; stop at the next instruction boundary.
- `bp_en`  in  NUM_BP: per-breakpoint enable.
- `bp_addr`  in  32*NUM_BP: breakpoint PCs; slot i is `[32*i+31:32*i]`.
- `pc`  in  32: current PC register value.
- `mem_access`  in  1: `MemRead | MemWr` of the current instruction.
- `mem_ready`  in  1: data memory completion, sampled in MEM.
- `pc_en`  out  1: PC register load enable.
- `reg_wr_en`  out  1: gate for `RegWr`.
- `mem_wr_en`  out  1: gate for `MemWr`.
- `halted`  out  1: 1 while in HALT.
- `bp_hit`  out  1: sticky; set when a breakpoint stops execution.
- `retire_count`  out  32: retired-instruction count.
- `state`  out  3: current FSM state, for debug.

## Operation
FSM states:
- **S_HALT**
  - Outputs: `halted`=1; all enables 0.
  - If `step_req` -> S_FETCH, set `step_pend`, set `skip_bp`.
  - Else if `run_req` -> S_FETCH, set `skip_bp`.
  - `step_req` has priority over `run_req`. `halt_req` is ignored in this state.
  - Leaving S_HALT clears `bp_hit`.
- **S_FETCH**
  - Gives the synchronous instruction memory one cycle to read.
  - Breakpoint check: an enabled slot whose `bp_addr` equals `pc` while `skip_bp`=0 -> S_HALT, set `bp_hit`. No enables are raised and the count is unchanged.
  - Otherwise -> S_EXEC.
  - `skip_bp` clears on exit from S_FETCH, so the instruction at a breakpoint can be resumed or stepped.
- **S_EXEC**
  - Decode/ALU settle cycle.
  - If `mem_access` -> S_MEM, else -> S_RETIRE.
- **S_MEM**
  - Output: `mem_wr_en`=1 for every cycle spent here; repeated writes of the same address and data are idempotent.
  - Waits for `mem_ready`=1 with no timeout, then -> S_RETIRE.
- **S_RETIRE**
  - Outputs: `pc_en`=1 and `reg_wr_en`=1 for exactly this cycle.
  - `retire_count` increments.
  - If `step_pend`, `halt_pend` or !`run_req` -> S_HALT and clear both pending flags. Otherwise -> S_FETCH.

Pending flags:
- `halt_req` in any non-HALT state sets `halt_pend`.
- The instruction in flight always completes. Halting never aborts mid-instruction.

Counter: `retire_count` is modulo 2^32 and wraps from 0xFFFF_FFFF to 0.

## Timing
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- Reset values: state=S_HALT, `halted`=1, `pc_en`/`reg_wr_en`/`mem_wr_en`=0, `bp_hit`=0, `retire_count`=0. All internal flags=0.
- Reset mid-instruction: on the next edge the FSM is in S_HALT and no enable pulses follow, even if the FSM was in S_MEM or S_RETIRE.
- Latency:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, RETIRE).
  - Memory instruction: 3 + N cycles, where N ≥ 1 is the number of cycles in S_MEM including the `mem_ready` cycle.
- `pc_en` pulses once per retired instruction. The new `pc` is visible in the following S_FETCH.
- `halted` rises on the cycle after S_RETIRE, or after the breakpoint S_FETCH.
- `halt_req` and `step_req` may be single-cycle pulses and must not be lost.

## Structure
- Package `seq_pkg` contains:
  - `seq_state_t` enum, 3 bits: S_HALT=0, S_FETCH=1, S_EXEC=2, S_MEM=3, S_RETIRE=4.
  - `localparam` `SEQ_CNT_W`=32.
- Sub-module `bp_match`: parameterised `NUM_BP` comparator bank. Inputs are `pc`, `bp_en` and `bp_addr`; output is a 1-bit `hit`. It is purely combinational and is instantiated once.
- The FSM, pending flags and counter live in `core_sequencer`.

## Test plan
- **Reset, then run:** reset, raise `run_req`, non-memory instructions.
  - Expect `pc_en` pulsing every 3rd cycle and `retire_count`=4 after 12 cycles.
- **Memory wait:** `mem_access`=1, `mem_ready` held low for 2 cycles, then high.
  - Expect `mem_wr_en` high for exactly 3 cycles, `pc_en` 1 cycle later, and 6 cycles total.
- **Step:** from halt, pulse `step_req` once.
  - Expect one `pc_en` pulse, `retire_count`+1, and `halted` back to 1 at cycle 4.
  - Also pulse `step_req` and `run_req` together: exactly one instruction executes.
- **Breakpoint:** `bp_en[1]`=1, `bp_addr[1]`=0x10, run from PC 0.
  - Expect a halt with `bp_hit`=1 and `retire_count`=4.
  - Then pulse `step_req`: the instruction at 0x10 retires and `bp_hit` clears.
- **Halt and reset mid-instruction:**
  - `halt_req` pulsed in S_EXEC: the instruction still retires, then the FSM halts.
  - `rst` asserted in S_MEM: next cycle state=0, no `pc_en` or `mem_wr_en`, count=0.
- **Counter wrap:** force `retire_count` to 0xFFFF_FFFF, retire one instruction.
  - Expect `retire_count`=0.
